cmp_result_tracker: RTL
=======================

Name: cmp_result_tracker

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Consumes a stream of comparator results (Data_in_A, Data_in_B, less/equal/greater) under a valid/ready handshake.
- Tallies the outcomes over a fixed window of samples, detects runs of consecutive equal results, and emits a per-window summary under a second valid/ready handshake.

Parameters:
- WIDTH, 4, operand width of Data_in_A/Data_in_B.
- WINDOW, 8, samples per summary window; legal range 1..255.
- CNT_W, 8, width of the outcome counters; must satisfy 2^CNT_W - 1 >= WINDOW.
- RUN_LEN, 3, number of consecutive equal results that raises run_hit; legal range >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  comparator result is valid this cycle
- in_ready  out  1  tracker accepts the result
- Data_in_A  in  WIDTH  operand A that accompanies the result
- Data_in_B  in  WIDTH  operand B that accompanies the result
- less  in  1  comparator flag: A < B
- equal  in  1  comparator flag: A == B
- greater  in  1  comparator flag: A > B
- clear  in  1  synchronous abort: discard the current window
- less_cnt  out  CNT_W  less count in the current or reported window
- equal_cnt  out  CNT_W  equal count in the current or reported window
- greater_cnt  out  CNT_W  greater count in the current or reported window
- run_hit  out  1  one-cycle pulse when the equal run reaches RUN_LEN
- out_valid  out  1  window summary is valid
- out_ready  in  1  downstream accepts the summary
- out_class  out  2  dominant outcome: 00 tie, 01 less, 10 equal, 11 greater
- err_flag  out  1  sticky consistency error (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): state=ACCUM; all counters, sample count and run count =0; in_ready=1; out_valid=0; out_class=00; run_hit=0; err_flag=0. Reset mid-window discards the partial window.
- Accept: a sample is accepted when in_valid && in_ready. Exactly one counter increments, chosen by priority greater > equal > less. If no flag is set, the sample still counts toward WINDOW but no outcome counter increments.
- FSM state ACCUM: in_ready=1. Each accept increments the sample count. The accept that brings the count to WINDOW moves the FSM to REPORT on the next edge and registers out_class. The counters then hold the final window values.
- FSM state REPORT: out_valid=1; in_ready=0 (back-pressure to upstream); out_class, the counters and out_valid stay stable until out_ready. On out_valid && out_ready: the counters, sample count and run count clear, and the FSM returns to ACCUM on the next edge. Latency from the final accept to out_valid=1 is 1 cycle.
- out_class: the strictly largest of the three counts selects the code. Any tie for the maximum gives 00. All-zero counts give 00.
- Run detection: an accepted equal result increments the run count. Any other accepted result sets it to 0. run_hit pulses for one cycle on the edge where the run count becomes exactly RUN_LEN. The run count saturates at RUN_LEN, so a run produces no repeat pulse until it breaks. The run count clears at each window handoff, so runs never span windows.
- Cycles with in_valid=0 leave all state unchanged.
- clear: in ACCUM, clear=1 zeroes the counters, sample count and run count; an accept in the same cycle is discarded. In REPORT, clear is ignored.
- WINDOW=1: every accept produces a REPORT.

Optional Feature:
- Macro: CMP_CONSISTENCY_CHECK_EN.
- Defined: on every accept, the block checks that {less,equal,greater} is one-hot and matches an internal compare of Data_in_A vs Data_in_B. A mismatch sets err_flag. err_flag is sticky and clears only on reset. Counting follows the internal compare, not the flags.
- Undefined: err_flag is tied to 0 and Data_in_A/Data_in_B are unused. Counting follows the flag priority rule above.

Decomposition:
- Package cmp_tracker_pkg holds the FSM state enum (ACCUM, REPORT) and the out_class codes (CLS_TIE, CLS_LESS, CLS_EQUAL, CLS_GREATER).
- One sub-module, cmp_run_detector, holds the run count, the saturation and the run_hit pulse. It takes accept, is_equal and a flush input.

Test Plan:
- Reset then 8 accepts of (A=10,B=12,less) -> out_valid=1 one cycle after the 8th accept; less_cnt=8; out_class=01; in_ready=0 until out_ready.
- Window of 3 greater (15,11), 3 equal (10,10), 2 less -> out_class=00 (tie); counts 2/3/3.
- 5 consecutive equal accepts (10,10) -> run_hit pulses once, on the 3rd accept; a less result then 3 more equal accepts -> a second pulse.
- Hold out_ready=0 for 10 cycles in REPORT with in_valid=1 -> no accepts, and the counts and out_class are stable; out_ready=1 -> counters read 0 and in_ready=1 on the next cycle.
- Assert rst_n=0 after 5 accepts, then release -> all counts 0, out_valid=0, and a full 8 new accepts are needed to report.
- With CMP_CONSISTENCY_CHECK_EN: inject (A=15,B=11,less=1) -> err_flag=1 and remains 1; greater_cnt increments.

Source files
------------

// File: rtl/cmp_tracker_pkg.sv
// Shared types for the comparator result tracker: FSM states and dominant-outcome codes.
package cmp_tracker_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CLS_TIE     = 2'b00,
        CLS_LESS    = 2'b01,
        CLS_EQUAL   = 2'b10,
        CLS_GREATER = 2'b11
    } cls_e;

endpackage

// File: rtl/cmp_result_tracker_run.sv
// cmp_run_detector: counts consecutive accepted equal results and pulses run_hit_o
// once when the run reaches RUN_LEN; the count saturates until the run breaks.
module cmp_run_detector #(
    parameter int RUN_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept_i,
    input  logic is_equal_i,
    input  logic flush_i,
    output logic run_hit_o
);
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

    logic [RW-1:0] run_q, run_d;
    logic          hit_q, hit_d;

    always_comb begin
        run_d = run_q;
        hit_d = 1'b0;
        if (flush_i) begin
            run_d = '0;
        end else if (accept_i) begin
            if (!is_equal_i) begin
                run_d = '0;
            end else if (run_q != RUN_MAX) begin
                run_d = run_q + 1'b1;
                hit_d = (run_q == RUN_MAX - 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
            hit_q <= 1'b0;
        end else begin
            run_q <= run_d;
            hit_q <= hit_d;
        end
    end

    assign run_hit_o = hit_q;

endmodule

// File: rtl/cmp_result_tracker.sv
// Windowed tally of comparator outcomes with run detection and a handshaked summary.
// Optional macro CMP_CONSISTENCY_CHECK_EN: recompute A vs B, count from it, flag mismatches.
module cmp_result_tracker #(
    parameter int WIDTH   = 4,
    parameter int WINDOW  = 8,
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Data_in_A,
    input  logic [WIDTH-1:0] Data_in_B,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    input  logic             clear,
    output logic [CNT_W-1:0] less_cnt,
    output logic [CNT_W-1:0] equal_cnt,
    output logic [CNT_W-1:0] greater_cnt,
    output logic             run_hit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_class,
    output logic             err_flag
);
    import cmp_tracker_pkg::*;

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] less_q, less_d, equal_q, equal_d, greater_q, greater_d;
    logic [CNT_W-1:0] sample_q, sample_d;
    cls_e             cls_q, cls_d;
    logic             inc_l, inc_e, inc_g;
    logic             accept, handoff, flush;

    function automatic cls_e classify(input logic [CNT_W-1:0] l, e, g);
        if (g > e && g > l) return CLS_GREATER;
        if (e > g && e > l) return CLS_EQUAL;
        if (l > g && l > e) return CLS_LESS;
        return CLS_TIE;
    endfunction

`ifdef CMP_CONSISTENCY_CHECK_EN
    logic cmp_lt, cmp_eq, cmp_gt, err_q;

    assign cmp_lt = (Data_in_A < Data_in_B);
    assign cmp_eq = (Data_in_A == Data_in_B);
    assign cmp_gt = (Data_in_A > Data_in_B);
    assign inc_l  = cmp_lt;
    assign inc_e  = cmp_eq;
    assign inc_g  = cmp_gt;

    // Exact match against the recomputed compare also enforces one-hot flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && ({less, equal, greater} != {cmp_lt, cmp_eq, cmp_gt})) begin
            err_q <= 1'b1;
        end
    end
    assign err_flag = err_q;
`else
    logic unused_operands;

    assign unused_operands = ^{Data_in_A, Data_in_B};
    assign inc_g    = greater;
    assign inc_e    = equal & ~greater;
    assign inc_l    = less & ~equal & ~greater;
    assign err_flag = 1'b0;
`endif

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == REPORT);
    assign accept    = in_valid && in_ready && !clear;
    assign handoff   = out_valid && out_ready;
    assign flush     = (in_ready && clear) || handoff;

    always_comb begin
        state_d   = state_q;
        less_d    = less_q;
        equal_d   = equal_q;
        greater_d = greater_q;
        sample_d  = sample_q;
        cls_d     = cls_q;
        if (state_q == ACCUM) begin
            if (clear) begin
                less_d    = '0;
                equal_d   = '0;
                greater_d = '0;
                sample_d  = '0;
            end else if (accept) begin
                less_d    = less_q + CNT_W'(inc_l);
                equal_d   = equal_q + CNT_W'(inc_e);
                greater_d = greater_q + CNT_W'(inc_g);
                sample_d  = sample_q + 1'b1;
                if (sample_d == WIN_LAST) begin
                    state_d = REPORT;
                    cls_d   = classify(less_d, equal_d, greater_d);
                end
            end
        end else if (out_ready) begin
            less_d    = '0;
            equal_d   = '0;
            greater_d = '0;
            sample_d  = '0;
            state_d   = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            less_q    <= '0;
            equal_q   <= '0;
            greater_q <= '0;
            sample_q  <= '0;
            cls_q     <= CLS_TIE;
        end else begin
            state_q   <= state_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
            greater_q <= greater_d;
            sample_q  <= sample_d;
            cls_q     <= cls_d;
        end
    end

    cmp_run_detector #(.RUN_LEN(RUN_LEN)) u_run (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept_i   (accept),
        .is_equal_i (inc_e),
        .flush_i    (flush),
        .run_hit_o  (run_hit)
    );

    assign less_cnt    = less_q;
    assign equal_cnt   = equal_q;
    assign greater_cnt = greater_q;
    assign out_class   = cls_q;

endmodule
